// File: rtl/embalagem_pkg.sv
// Shared definitions for the wine conveyor packing station.
//   estado_e       : FSM state codes exported on controle_embalagem.estado
//   LARG_ESTADO    : width of the state code
//   LARG_GARRAFAS  : width of the per-box bottle counter
package embalagem_pkg;

  localparam int unsigned LARG_ESTADO   = 3;
  localparam int unsigned LARG_GARRAFAS = 4;

  typedef enum logic [LARG_ESTADO-1:0] {
    OCIOSO        = 3'd0,
    AGUARDA_CAIXA = 3'd1,
    ENCHENDO      = 3'd2,
    EJETANDO      = 3'd3,
    FALHA         = 3'd4
  } estado_e;

endpackage

// File: rtl/sincronizador_borda.sv
// Two-flop synchronizer for an asynchronous field input, followed by a
// registered rising-edge detector.
//   clk, reset   : system clock, asynchronous active-high reset
//   entrada      : raw asynchronous input
//   nivel        : synchronized level (2 clk edges of latency)
//   borda_subida : one-cycle pulse, registered on the 3rd edge after the raw
//                  rise is first sampled
module sincronizador_borda (
  input  logic clk,
  input  logic reset,
  input  logic entrada,
  output logic nivel,
  output logic borda_subida
);

  logic [1:0] sinc_q;
  logic       nivel_ant_q;
  logic       borda_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sinc_q      <= 2'b00;
      nivel_ant_q <= 1'b0;
      borda_q     <= 1'b0;
    end else begin
      sinc_q      <= {sinc_q[0], entrada};
      nivel_ant_q <= sinc_q[1];
      borda_q     <= sinc_q[1] & ~nivel_ant_q;
    end
  end

  assign nivel        = sinc_q[1];
  assign borda_subida = borda_q;

endmodule

// File: rtl/controle_embalagem.sv
// Packing station controller: runs the belt, counts bottles into the current
// box, fires the ejector on a full box and pulses the downstream dozen counter.
//   clk, reset                          : clock, asynchronous active-high reset
//   iniciar, parar, reconhecer          : operator start / stop / fault ack
//   sensor_garrafa, caixa_ok, ejecao_fim: asynchronous field sensors
//   motor_esteira, ejetor, alarme       : actuators and fault lamp
//   inc_garrafa                         : one pulse per accepted bottle
//   garrafas_caixa, caixas_completas    : bottle and completed-box counters
//   estado                              : current state code
// Optional macro EJECAO_TIMEOUT_EN: fault if the ejector stroke does not end
// within TIMEOUT_EJECAO cycles.
module controle_embalagem
  import embalagem_pkg::*;
#(
  parameter int unsigned GARRAFAS_POR_CAIXA = 6,
  parameter int unsigned TIMEOUT_EJECAO     = 1000,
  parameter int unsigned LARG_CAIXAS        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iniciar,
  input  logic                     parar,
  input  logic                     reconhecer,
  input  logic                     sensor_garrafa,
  input  logic                     caixa_ok,
  input  logic                     ejecao_fim,
  output logic                     motor_esteira,
  output logic                     ejetor,
  output logic                     inc_garrafa,
  output logic                     alarme,
  output logic [LARG_GARRAFAS-1:0] garrafas_caixa,
  output logic [LARG_CAIXAS-1:0]   caixas_completas,
  output logic [LARG_ESTADO-1:0]   estado
);

  localparam logic [LARG_GARRAFAS-1:0] ULTIMA = LARG_GARRAFAS'(GARRAFAS_POR_CAIXA - 1);

  estado_e                  state_q, state_d;
  logic [LARG_GARRAFAS-1:0] garrafas_q, garrafas_d;
  logic [LARG_CAIXAS-1:0]   caixas_q, caixas_d;
  logic                     parar_pend_q, parar_pend_d;

  logic garrafa_borda, caixa_nivel, fim_nivel;
  logic unused_bordas;

  sincronizador_borda u_sinc_garrafa (
    .clk          (clk),
    .reset        (reset),
    .entrada      (sensor_garrafa),
    .nivel        (),
    .borda_subida (garrafa_borda)
  );

  logic garrafa_nivel_unused, caixa_borda_unused, fim_borda_unused;

  sincronizador_borda u_sinc_caixa (
    .clk          (clk),
    .reset        (reset),
    .entrada      (caixa_ok),
    .nivel        (caixa_nivel),
    .borda_subida (caixa_borda_unused)
  );

  sincronizador_borda u_sinc_fim (
    .clk          (clk),
    .reset        (reset),
    .entrada      (ejecao_fim),
    .nivel        (fim_nivel),
    .borda_subida (fim_borda_unused)
  );

  assign garrafa_nivel_unused = 1'b0;
  assign unused_bordas = ^{caixa_borda_unused, fim_borda_unused, garrafa_nivel_unused};

`ifdef EJECAO_TIMEOUT_EN
  localparam int unsigned LARG_TIMER = $clog2(TIMEOUT_EJECAO + 1);
  logic [LARG_TIMER-1:0] timer_q;
  logic                  timeout;

  // Held at zero outside EJETANDO, so it starts from zero on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (state_q != EJETANDO) begin
      timer_q <= '0;
    end else if (!timeout) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  assign timeout = (timer_q == LARG_TIMER'(TIMEOUT_EJECAO));
`endif

  // State register and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= OCIOSO;
      garrafas_q   <= '0;
      caixas_q     <= '0;
      parar_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      garrafas_q   <= garrafas_d;
      caixas_q     <= caixas_d;
      parar_pend_q <= parar_pend_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    garrafas_d   = garrafas_q;
    caixas_d     = caixas_q;
    parar_pend_d = parar_pend_q;
    unique case (state_q)
      OCIOSO: begin
        if (iniciar && !parar) state_d = AGUARDA_CAIXA;
      end
      AGUARDA_CAIXA: begin
        if (parar)            state_d = OCIOSO;
        else if (caixa_nivel) state_d = ENCHENDO;
      end
      ENCHENDO: begin
        // The bottle is always counted, even when the box vanishes or stop is
        // pressed in the same cycle.
        if (garrafa_borda) garrafas_d = (garrafas_q == ULTIMA) ? '0 : garrafas_q + 1'b1;
        if (!caixa_nivel) begin
          state_d = FALHA;
        end else if (garrafa_borda && (garrafas_q == ULTIMA)) begin
          // A full box is always ejected; a simultaneous stop is deferred.
          state_d      = EJETANDO;
          parar_pend_d = parar;
        end else if (parar) begin
          state_d = OCIOSO;
        end
      end
      EJETANDO: begin
        if (parar) parar_pend_d = 1'b1;
        if (fim_nivel) begin
          caixas_d     = caixas_q + 1'b1;
          state_d      = (parar_pend_q || parar) ? OCIOSO : AGUARDA_CAIXA;
          parar_pend_d = 1'b0;
        end
`ifdef EJECAO_TIMEOUT_EN
        else if (timeout) begin
          state_d      = FALHA;
          parar_pend_d = 1'b0;
        end
`endif
      end
      FALHA: begin
        if (reconhecer) state_d = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase
  end

  // Outputs, decoded from the registered state.
  always_comb begin
    motor_esteira = (state_q == ENCHENDO);
    ejetor        = (state_q == EJETANDO);
    alarme        = (state_q == FALHA);
    inc_garrafa   = (state_q == ENCHENDO) && garrafa_borda;
  end

  assign garrafas_caixa   = garrafas_q;
  assign caixas_completas = caixas_q;
  assign estado           = state_q;

endmodule

// File: tb/tb_controle_embalagem.sv
module tb_controle_embalagem;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0, parar = 1'b0, reconhecer = 1'b0;
  logic       sensor_garrafa = 1'b0, caixa_ok = 1'b0, ejecao_fim = 1'b0;
  logic       motor_esteira, ejetor, inc_garrafa, alarme;
  logic [3:0] garrafas_caixa;
  logic [7:0] caixas_completas;
  logic [2:0] estado;

  int checks = 0;
  int errors = 0;

  int exp_inc[$];    // expected garrafas_caixa seen with each inc_garrafa
  int exp_state[$];  // expected sequence of estado changes
  logic [2:0] ultimo_estado = 3'd0;

  controle_embalagem dut (
    .clk              (clk),
    .reset            (reset),
    .iniciar          (iniciar),
    .parar            (parar),
    .reconhecer       (reconhecer),
    .sensor_garrafa   (sensor_garrafa),
    .caixa_ok         (caixa_ok),
    .ejecao_fim       (ejecao_fim),
    .motor_esteira    (motor_esteira),
    .ejetor           (ejetor),
    .inc_garrafa      (inc_garrafa),
    .alarme           (alarme),
    .garrafas_caixa   (garrafas_caixa),
    .caixas_completas (caixas_completas),
    .estado           (estado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nome, input int atual, input int esperado);
    checks++;
    if (atual != esperado) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
    end
  endtask

  // Monitor: each inc_garrafa pulse must match a queued bottle.
  always @(negedge clk) begin
    if (inc_garrafa === 1'b1) begin
      checks++;
      if (exp_inc.size() == 0) begin
        errors++;
        $display("FAIL inc_unexpected: got inc_garrafa=1 count=%0d expected no pulse",
                 garrafas_caixa);
      end else begin
        int e;
        e = exp_inc.pop_front();
        if (int'(garrafas_caixa) != e) begin
          errors++;
          $display("FAIL inc_count: got %0d expected %0d", garrafas_caixa, e);
        end
      end
    end
  end

  // Monitor: every change of estado must match the next queued state.
  always @(negedge clk) begin
    if (estado !== ultimo_estado) begin
      checks++;
      if (exp_state.size() == 0) begin
        errors++;
        $display("FAIL state_unexpected: got %0d (from %0d) expected no change",
                 estado, ultimo_estado);
      end else begin
        int e;
        e = exp_state.pop_front();
        if (int'(estado) != e) begin
          errors++;
          $display("FAIL state_seq: got %0d expected %0d", estado, e);
        end
      end
      ultimo_estado = estado;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // 2 cycles high, 3 low; the count update lands inside the task.
  task automatic garrafa();
    sensor_garrafa = 1'b1;
    tick(2);
    sensor_garrafa = 1'b0;
    tick(3);
  endtask

  task automatic pulso(input int qual);
    if (qual == 0) iniciar = 1'b1;
    else if (qual == 1) parar = 1'b1;
    else reconhecer = 1'b1;
    tick(1);
    iniciar = 1'b0;
    parar = 1'b0;
    reconhecer = 1'b0;
  endtask

  task automatic fim_ejecao();
    ejecao_fim = 1'b1;
    tick(2);
    ejecao_fim = 1'b0;
    tick(4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("reset_outs", int'({motor_esteira, ejetor, inc_garrafa, alarme}), 0);
    chk("reset_cnt", int'(garrafas_caixa) + int'(caixas_completas) + int'(estado), 0);
    reset = 1'b0;
    tick(2);

    // Full box of six bottles, then ejection.
    exp_state.push_back(1);
    pulso(0);
    exp_state.push_back(2);
    caixa_ok = 1'b1;
    tick(4);
    chk("enchendo_motor", int'(motor_esteira), 1);
    for (int b = 0; b < 6; b++) begin
      exp_inc.push_back(b);
      if (b == 5) exp_state.push_back(3);
      garrafa();
    end
    chk("ejet_ejetor", int'(ejetor), 1);
    chk("ejet_motor", int'(motor_esteira), 0);
    chk("ejet_count", int'(garrafas_caixa), 0);
    caixa_ok = 1'b0;  // ignored while ejecting
    tick(4);
    chk("ejet_hold", int'(estado), 3);
    exp_state.push_back(1);
    fim_ejecao();
    chk("caixas_1", int'(caixas_completas), 1);
    chk("aguarda", int'(estado), 1);
    chk("aguarda_ejetor", int'(ejetor), 0);

    // Partial box, stop, resume.
    exp_state.push_back(2);
    caixa_ok = 1'b1;
    tick(4);
    for (int b = 0; b < 3; b++) begin
      exp_inc.push_back(b);
      garrafa();
    end
    exp_state.push_back(0);
    pulso(1);
    tick(2);
    chk("stop_count", int'(garrafas_caixa), 3);
    chk("stop_motor", int'(motor_esteira), 0);
    garrafa();  // ignored in OCIOSO
    chk("ocioso_ignore", int'(garrafas_caixa), 3);
    exp_state.push_back(1);
    exp_state.push_back(2);
    pulso(0);
    tick(3);
    for (int b = 3; b < 6; b++) begin
      exp_inc.push_back(b);
      if (b == 5) exp_state.push_back(3);
      garrafa();
    end
    chk("resume_ejet", int'(estado), 3);
    garrafa();  // ignored in EJETANDO
    chk("ejet_ignore", int'(garrafas_caixa), 0);
    pulso(1);   // deferred stop
    caixa_ok = 1'b0;
    tick(2);
    chk("deferred_stop", int'(estado), 3);
    exp_state.push_back(0);
    fim_ejecao();
    chk("caixas_2", int'(caixas_completas), 2);

    // parar wins over iniciar; box removed mid-fill.
    iniciar = 1'b1;
    parar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    parar = 1'b0;
    tick(3);
    chk("parar_wins", int'(estado), 0);
    exp_state.push_back(1);
    pulso(0);
    exp_state.push_back(2);
    caixa_ok = 1'b1;
    tick(4);
    for (int b = 0; b < 2; b++) begin
      exp_inc.push_back(b);
      garrafa();
    end
    exp_state.push_back(4);
    caixa_ok = 1'b0;
    tick(5);
    chk("falha_alarme", int'(alarme), 1);
    chk("falha_motor", int'(motor_esteira), 0);
    pulso(1);   // ignored in FALHA
    tick(2);
    chk("falha_parar", int'(estado), 4);
    exp_state.push_back(0);
    pulso(2);
    tick(2);
    chk("ack_alarme", int'(alarme), 0);
    chk("ack_count", int'(garrafas_caixa), 2);

    // No timeout in the default build: ejector waits.
    exp_state.push_back(1);
    pulso(0);
    exp_state.push_back(2);
    caixa_ok = 1'b1;
    tick(4);
    for (int b = 2; b < 6; b++) begin
      exp_inc.push_back(b);
      if (b == 5) exp_state.push_back(3);
      garrafa();
    end
    tick(100);
    chk("no_timeout", int'(estado), 3);
    chk("no_timeout_ej", int'(ejetor), 1);
    exp_state.push_back(1);
    exp_state.push_back(2);
    fim_ejecao();
    chk("caixas_3", int'(caixas_completas), 3);

    // Asynchronous reset mid-fill at count 4.
    for (int b = 0; b < 4; b++) begin
      exp_inc.push_back(b);
      garrafa();
    end
    chk("pre_reset_cnt", int'(garrafas_caixa), 4);
    @(posedge clk);
    #2;
    exp_state.push_back(0);
    reset = 1'b1;
    caixa_ok = 1'b0;
    #1;
    chk("async_outs", int'({motor_esteira, ejetor, inc_garrafa, alarme}), 0);
    chk("async_cnt", int'(garrafas_caixa) + int'(caixas_completas) + int'(estado), 0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // 256 boxes: completed-box counter wraps.
    exp_state.push_back(1);
    pulso(0);
    exp_state.push_back(2);
    caixa_ok = 1'b1;
    tick(4);
    for (int i = 0; i < 256; i++) begin
      for (int b = 0; b < 6; b++) begin
        exp_inc.push_back(b);
        if (b == 5) exp_state.push_back(3);
        garrafa();
      end
      exp_state.push_back(1);
      exp_state.push_back(2);
      fim_ejecao();
      if (i == 254) chk("caixas_255", int'(caixas_completas), 255);
      if (i == 255) chk("caixas_wrap", int'(caixas_completas), 0);
    end

    tick(5);
    chk("inc_queue_empty", exp_inc.size(), 0);
    chk("state_queue_empty", exp_state.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
